// File: rtl/arith_shift_sequencer.sv
// arith_shift_sequencer: multi-cycle 4-bit arithmetic shifter.
// A start request in IDLE captures one operand (A or B), a direction and a
// shift distance. The block then performs one 1-bit shift per SHIFT cycle and
// publishes the result on `out` as it enters DONE.
// Optional feature: define ARITH_SHIFT_OVF_EN to add the `ovf` output.
// `ovf` is a sticky flag that reports a sign change during left shifts.
//
// Handshake: start is a request pulse that is only honoured in IDLE. While
// busy is high, or during the single done cycle, start is dropped and is not
// queued. done is a one-cycle pulse, and out/ovf are valid from that cycle
// until the next completion.
module arith_shift_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] Sel,
  input  logic [2:0] amount,
  output logic [3:0] out,
  output logic       busy,
  output logic       done
`ifdef ARITH_SHIFT_OVF_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] count;
  logic [3:0] r;
  logic       dir_left;
  logic [3:0] operand;
  logic [3:0] shifted;

`ifdef ARITH_SHIFT_OVF_EN
  logic       ovf_acc;
  logic       step_ovf;
`endif

  // Operand selection and the one-step arithmetic shift of the working register
  always_comb begin
    operand = Sel[1] ? B : A;
    shifted = dir_left ? {r[2:0], 1'b0} : {r[3], r[3:1]};
  end

`ifdef ARITH_SHIFT_OVF_EN
  // A left step changes the sign when the two top bits differ before the step
  always_comb begin
    step_ovf = dir_left & (r[3] ^ r[2]);
  end
`endif

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Sequencer FSM: capture, one shift per cycle, then register the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 3'd0;
      r        <= 4'd0;
      dir_left <= 1'b0;
      out      <= 4'd0;
`ifdef ARITH_SHIFT_OVF_EN
      ovf_acc  <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r        <= operand;
            dir_left <= Sel[0];
            count    <= amount;
`ifdef ARITH_SHIFT_OVF_EN
            ovf_acc  <= 1'b0;
`endif
            if (amount == 3'd0) begin
              // A zero-distance shift completes immediately with the operand
              out   <= operand;
`ifdef ARITH_SHIFT_OVF_EN
              ovf   <= 1'b0;
`endif
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r     <= shifted;
          count <= count - 3'd1;
`ifdef ARITH_SHIFT_OVF_EN
          ovf_acc <= ovf_acc | step_ovf;
`endif
          if (count == 3'd1) begin
            out   <= shifted;
`ifdef ARITH_SHIFT_OVF_EN
            ovf   <= ovf_acc | step_ovf;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Testbench for arith_shift_sequencer.
// It runs a table of directed vectors and then a set of modelled random
// operations. It also runs hand-written sequences for reset and abort, and for
// start requests that arrive during a shift.
// Build with ARITH_SHIFT_OVF_EN defined to also check the ovf output.
module tb_arith_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] sel;
  logic [2:0] amount;
  logic [3:0] out;
  logic       busy;
  logic       done;
`ifdef ARITH_SHIFT_OVF_EN
  logic       ovf;
`endif

  // Clock generation
  always #5 clk = ~clk;

  arith_shift_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (a),
    .B      (b),
    .Sel    (sel),
    .amount (amount),
    .out    (out),
    .busy   (busy),
    .done   (done)
`ifdef ARITH_SHIFT_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [2:0] amt;
    logic [3:0] exp_out;
    logic       exp_ovf;
  } vec_t;

  vec_t       vecs[11];
  logic [4:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] last_out;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, result}
  function automatic logic [4:0] model(input logic [3:0] a_i, input logic [3:0] b_i,
                                       input logic [1:0] sel_i, input logic [2:0] amt_i);
    logic [3:0] op;
    logic [3:0] res;
    logic [7:0] ext;
    logic       ov;
    op = sel_i[1] ? b_i : a_i;
    ov = 1'b0;
    if (sel_i[0]) begin
      res = op << amt_i;
      ext = {op, 4'b0000};
      for (int i = 0; i < int'(amt_i); i++)
        if (ext[7-i] !== ext[6-i]) ov = 1'b1;
    end else begin
      res = 4'($signed(op) >>> amt_i);
    end
    return {ov, res};
  endfunction

  // One operation: drive start, follow busy, then compare the result on done
  task automatic run_op(input logic [3:0] a_i, input logic [3:0] b_i, input logic [1:0] sel_i,
                        input logic [2:0] amt_i, input logic [4:0] exp_i, input bit disturb);
    int         cyc;
    logic [4:0] e;
    @(negedge clk);
    check("idle_before_start", {3'b000, busy, done}, 5'd0);
    a = a_i; b = b_i; sel = sel_i; amount = amt_i; start = 1'b1;
    exp_q.push_back(exp_i);
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (done) break;
      check("busy_in_shift", {4'd0, busy}, 5'd1);
      check("out_hold", {1'b0, out}, {1'b0, last_out});
      if (disturb) begin
        start = 1'b1; a = ~a_i; b = ~b_i;
        sel = 2'($urandom_range(0, 3)); amount = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 5'd0, 5'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("latency", 5'(cyc), 5'(int'(amt_i) + 1));
      check("busy_low_in_done", {4'd0, busy}, 5'd0);
      e = exp_q.pop_front();
      check("out", {1'b0, out}, {1'b0, e[3:0]});
`ifdef ARITH_SHIFT_OVF_EN
      check("ovf", {4'd0, ovf}, {4'd0, e[4]});
`endif
      last_out = e[3:0];
    end
  endtask

  initial begin
    bit   seen_done;
    logic [3:0] ra, rb;
    logic [1:0] rs;
    logic [2:0] rn;

    vecs[0]  = '{4'b1010, 4'b0101, 2'b00, 3'd2, 4'b1110, 1'b0};
    vecs[1]  = '{4'b0011, 4'b1111, 2'b01, 3'd1, 4'b0110, 1'b0};
    vecs[2]  = '{4'b0011, 4'b1111, 2'b01, 3'd2, 4'b1100, 1'b1};
    vecs[3]  = '{4'b0001, 4'b1000, 2'b10, 3'd7, 4'b1111, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0111, 2'b11, 3'd5, 4'b0000, 1'b1};
    vecs[5]  = '{4'b0101, 4'b1100, 2'b00, 3'd0, 4'b0101, 1'b0};
    vecs[6]  = '{4'b1001, 4'b0110, 2'b10, 3'd1, 4'b0011, 1'b0};
    vecs[7]  = '{4'b1001, 4'b0000, 2'b01, 3'd1, 4'b0010, 1'b1};
    vecs[8]  = '{4'b0000, 4'b1100, 2'b11, 3'd1, 4'b1000, 1'b0};
    vecs[9]  = '{4'b0111, 4'b1000, 2'b00, 3'd4, 4'b0000, 1'b0};
    vecs[10] = '{4'b1111, 4'b0001, 2'b01, 3'd3, 4'b1000, 1'b0};

    // Reset and initial state
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; sel = 2'd0; amount = 3'd0;
    last_out = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_out", {1'b0, out}, 5'd0);
    check("reset_busy_done", {3'b000, busy, done}, 5'd0);
`ifdef ARITH_SHIFT_OVF_EN
    check("reset_ovf", {4'd0, ovf}, 5'd0);
`endif
    rst = 1'b0;

    // Directed table, issued back to back
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].amt,
             {vecs[i].exp_ovf, vecs[i].exp_out}, 1'b0);

    // Start and input changes during SHIFT are ignored
    run_op(4'b1010, 4'b0000, 2'b00, 3'd3, 5'b0_1111, 1'b1);
    run_op(4'b0011, 4'b0100, 2'b01, 3'd2, 5'b1_1100, 1'b1);

    // Random operations against the model
    for (int k = 0; k < 16; k++) begin
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));  rn = 3'($urandom_range(0, 7));
      run_op(ra, rb, rs, rn, model(ra, rb, rs, rn), bit'($urandom_range(0, 1)));
    end

    // Reset at the 2nd SHIFT cycle of a 5-step shift aborts without done
    @(negedge clk);
    a = 4'b0110; sel = 2'b01; amount = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_1st", {4'd0, busy}, 5'd1);
    @(negedge clk);
    check("abort_busy_2nd", {4'd0, busy}, 5'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_idle", {3'b000, busy, done}, 5'd0);
    check("abort_out", {1'b0, out}, 5'd0);
`ifdef ARITH_SHIFT_OVF_EN
    check("abort_ovf", {4'd0, ovf}, 5'd0);
`endif
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", {4'd0, seen_done}, 5'd0);

    // Reset overrides a simultaneous start
    a = 4'b0101; sel = 2'b00; amount = 3'd0; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_over_start", {3'b000, busy, done}, 5'd0);
    last_out = 4'd0;

    // Normal operation resumes after reset
    run_op(4'b1000, 4'b0000, 2'b00, 3'd1, 5'b0_1100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arith_shift_sequencer.md
ARITH_SHIFT_SEQUENCER -- requirements
Module: arith_shift_sequencer

Interface
REQ-001 The block SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-003 The block SHALL have ports: start  input  1  request pulse, sampled only in IDLE.
REQ-004 The block SHALL have ports: A  input  4  operand A (two's complement).
REQ-005 The block SHALL have ports: B  input  4  operand B (two's complement).
REQ-006 The block SHALL have ports: Sel  input  2  00 A right, 01 A left, 10 B right, 11 B left.
REQ-007 The block SHALL have ports: amount  input  3  shift distance, 0..7 positions.
REQ-008 The block SHALL have ports: out  output  4  registered final result.
REQ-009 The block SHALL have ports: busy  output  1  high while in SHIFT.
REQ-010 The block SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have ports: ovf  output  1  left-shift sign-change flag (present only with ARITH_SHIFT_OVF_EN).

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, DONE; busy = (state==SHIFT), done = (state==DONE), both decoded from registered state.
REQ-013 In IDLE with start=1, the block SHALL capture on that edge: operand selected by Sel[1] (0 A, 1 B), direction Sel[0] (0 right, 1 left), count=amount.
REQ-014 On capture, the next state SHALL be DONE if amount==0, else SHIFT.
REQ-015 Each SHIFT cycle SHALL do exactly one 1-bit shift and decrement count; when count==1, the next state SHALL be DONE.
REQ-016 The right shift SHALL be arithmetic: r <= {r[3], r[3:1]} (sign replicated).
REQ-017 The left shift SHALL be arithmetic: r <= {r[2:0], 1'b0}.
REQ-018 out SHALL load the final shifted value on the edge entering DONE and SHALL hold it until the next completion.
REQ-019 Latency: done SHALL be high in the cycle following N+1 rising edges after the start-sampling edge, where N=amount (N=0 gives 1-cycle latency).
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 start in SHIFT or DONE SHALL be ignored (no queuing), and operand/Sel/amount changes after capture SHALL have no effect.
REQ-022 A new start SHALL be accepted in the first IDLE cycle after DONE (back-to-back throughput N+2 cycles).
REQ-023 Shifts beyond width SHALL saturate naturally: a right shift of 4..7 gives 0000 or 1111 per sign; a left shift of 4..7 gives 0000.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, count=0, shift register=0, out=0000, ovf=0; busy and done SHALL be 0 in the following cycle.
REQ-025 rst SHALL override start and SHALL abort any in-progress SHIFT with no done pulse.
REQ-026 rst SHALL have no effect between clock edges.

Configuration
REQ-027 When ARITH_SHIFT_OVF_EN is defined, ovf SHALL exist: cleared on capture, and set sticky if r[3]!=r[2] before any left-shift step.
REQ-028 When ARITH_SHIFT_OVF_EN is defined, ovf SHALL be registered with out on entry to DONE and held until the next completion.
REQ-029 When ARITH_SHIFT_OVF_EN is undefined, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 A=1010, Sel=00, amount=2, start 1 cycle -> busy 2 cycles, then done, out=1110.
REQ-031 A=0011, Sel=01, amount=1 -> out=0110, ovf=0; the same with amount=2 -> out=1100, ovf=1 (macro on).
REQ-032 B=1000, Sel=10, amount=7 -> out=1111; B=0111, Sel=11, amount=5 -> out=0000.
REQ-033 amount=0, A=0101, Sel=00 -> done in the next cycle, out=0101, busy never high.
REQ-034 start re-asserted during SHIFT with different A -> ignored, result reflects the first operand; rst asserted at the 2nd SHIFT cycle of amount=5 -> next cycle IDLE, out=0000, no done pulse.
